// File: rtl/fft_iter_addr_gen.sv
// Butterfly/layer counter and address datapath for the iterative in-place radix-2 FFT.
// Read and twiddle addresses come combinationally from the indices; write addresses are captured on BUT_STROB.
module fft_iter_addr_gen #(
  parameter int LAYERS = 5,
  parameter int ButtWL = 4,
  parameter int LayWL  = 3,
  parameter int AddrWL = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              ADDR_RST,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  input  logic              BUT_STROB,
  output logic [AddrWL-1:0] RD_ADDR_A,
  output logic [AddrWL-1:0] RD_ADDR_B,
  output logic [AddrWL-1:0] WR_ADDR_A,
  output logic [AddrWL-1:0] WR_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic [LayWL-1:0]  LAYER,
  output logic [ButtWL-1:0] BUT_IDX,
  output logic              DONE
);

  localparam logic [LayWL-1:0] LAST_LAYER = LayWL'(LAYERS);
  localparam logic [LayWL-1:0] LAST_STAGE = LayWL'(LAYERS - 1);

  logic [ButtWL-1:0] r_but;
  logic [LayWL-1:0]  r_lay;
  logic [AddrWL-1:0] r_wr_a;
  logic [AddrWL-1:0] r_wr_b;

  logic              w_done;
  logic [LayWL-1:0]  w_stage;
  logic [AddrWL-1:0] w_rd_a;
  logic [AddrWL-1:0] w_rd_b;
  logic [ButtWL-1:0] w_tw;

  // Insert bit v into butterfly index b at bit position s.
  function automatic logic [AddrWL-1:0] insert_bit(input logic [ButtWL-1:0] b,
                                                   input logic [LayWL-1:0]  s,
                                                   input logic              v);
    logic [AddrWL-1:0] bx;
    logic [AddrWL-1:0] mask;
    logic [AddrWL-1:0] ins;
    bx   = {1'b0, b};
    mask = (AddrWL'(1) << s) - AddrWL'(1);
    ins  = v ? (AddrWL'(1) << s) : AddrWL'(0);
    return ((bx & ~mask) << 1) | (bx & mask) | ins;
  endfunction

  // Twiddle index: low s bits of b, scaled up to the ROM's full-resolution step.
  function automatic logic [ButtWL-1:0] twiddle_idx(input logic [ButtWL-1:0] b,
                                                    input logic [LayWL-1:0]  s);
    logic [ButtWL-1:0] mask;
    mask = (ButtWL'(1) << s) - ButtWL'(1);
    return (b & mask) << (LAST_STAGE - s);
  endfunction

  // Address mapping; stage clamps to the last layer once the transform is finished.
  always_comb begin
    w_done  = (r_lay == LAST_LAYER);
    w_stage = r_lay;
    if (w_done) begin
      w_stage = LAST_STAGE;
    end else begin
      w_stage = r_lay;
    end
    w_rd_a = insert_bit(r_but, w_stage, 1'b0);
    w_rd_b = insert_bit(r_but, w_stage, 1'b1);
    w_tw   = twiddle_idx(r_but, w_stage);
  end

  // Index counters and write-address capture; ADDR_RST overrides the strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_but  <= '0;
      r_lay  <= '0;
      r_wr_a <= '0;
      r_wr_b <= '0;
    end else if (EN) begin
      if (ADDR_RST) begin
        r_but  <= '0;
        r_lay  <= '0;
        r_wr_a <= '0;
        r_wr_b <= '0;
      end else begin
        if (ADDR_EN && !w_done) begin
          r_but <= r_but + ButtWL'(1);
        end
        if (LAY_EN && !w_done) begin
          r_lay <= r_lay + LayWL'(1);
        end
        if (BUT_STROB) begin
          r_wr_a <= w_rd_a;
          r_wr_b <= w_rd_b;
        end
      end
    end
  end

  assign RD_ADDR_A = w_rd_a;
  assign RD_ADDR_B = w_rd_b;
  assign TW_ADDR   = w_tw;
  assign WR_ADDR_A = r_wr_a;
  assign WR_ADDR_B = r_wr_b;
  assign LAYER     = r_lay;
  assign BUT_IDX   = r_but;
  assign DONE      = w_done;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed self-checking bench for fft_iter_addr_gen: mapping points, full 5x16 transform, gating and resets.
module tb_fft_iter_addr_gen;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       EN = 1'b1;
  logic       ADDR_RST = 1'b0;
  logic       ADDR_EN = 1'b0;
  logic       LAY_EN = 1'b0;
  logic       BUT_STROB = 1'b0;
  logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [3:0] TW_ADDR, BUT_IDX;
  logic [2:0] LAYER;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  int cnt[32];

  fft_iter_addr_gen dut (
    .CLK(CLK), .RST(RST), .EN(EN), .ADDR_RST(ADDR_RST), .ADDR_EN(ADDR_EN),
    .LAY_EN(LAY_EN), .BUT_STROB(BUT_STROB), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .TW_ADDR(TW_ADDR), .LAYER(LAYER),
    .BUT_IDX(BUT_IDX), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobes held, then all strobes released.
  task automatic step(input logic en, input logic ar, input logic ae, input logic le, input logic bs);
    EN = en; ADDR_RST = ar; ADDR_EN = ae; LAY_EN = le; BUT_STROB = bs;
    @(posedge CLK); #1;
    EN = 1'b1; ADDR_RST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0; BUT_STROB = 1'b0;
  endtask

  task automatic goto(input int lay, input int but);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < lay; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < but; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  function automatic int exp_a(input int b, input int s);
    return (b >> s) * (1 << (s + 1)) + (b % (1 << s));
  endfunction

  function automatic int exp_tw(input int b, input int s);
    return ((b % (1 << s)) * (1 << (4 - s))) % 16;
  endfunction

  initial begin
    // Reset
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    check("rst_rd_a", RD_ADDR_A, 0);
    check("rst_rd_b", RD_ADDR_B, 1);
    check("rst_tw", TW_ADDR, 0);
    check("rst_wr_a", WR_ADDR_A, 0);
    check("rst_wr_b", WR_ADDR_B, 0);
    check("rst_layer", LAYER, 0);
    check("rst_but", BUT_IDX, 0);
    check("rst_done", DONE, 0);

    // Layer 2, butterfly 5
    goto(2, 5);
    check("l2_rd_a", RD_ADDR_A, 9);
    check("l2_rd_b", RD_ADDR_B, 13);
    check("l2_tw", TW_ADDR, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("l2_wr_a", WR_ADDR_A, 9);
    check("l2_wr_b", WR_ADDR_B, 13);

    // Layer 0 and layer 4
    goto(0, 5);
    check("l0_rd_a", RD_ADDR_A, 10);
    check("l0_rd_b", RD_ADDR_B, 11);
    check("l0_tw", TW_ADDR, 0);
    goto(4, 7);
    check("l4_rd_a", RD_ADDR_A, 7);
    check("l4_rd_b", RD_ADDR_B, 23);
    check("l4_tw", TW_ADDR, 7);

    // Full transform with the control-unit strobe pattern
    goto(0, 0);
    for (int l = 0; l < 5; l++) begin
      int bad;
      for (int a = 0; a < 32; a++) cnt[a] = 0;
      for (int b = 0; b < 16; b++) begin
        check("ft_rd_a", RD_ADDR_A, exp_a(b, l));
        check("ft_rd_b", RD_ADDR_B, exp_a(b, l) + (1 << l));
        check("ft_tw", TW_ADDR, exp_tw(b, l));
        cnt[RD_ADDR_A]++;
        cnt[RD_ADDR_B]++;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ft_wr_a", WR_ADDR_A, exp_a(b, l));
        check("ft_wr_b", WR_ADDR_B, exp_a(b, l) + (1 << l));
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, (b == 15), 1'b0);
      end
      bad = 0;
      for (int a = 0; a < 32; a++) if (cnt[a] != 1) bad++;
      check("ft_once_per_layer", bad, 0);
    end
    check("ft_layer", LAYER, 5);
    check("ft_done", DONE, 1);
    check("ft_but", BUT_IDX, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("done_but", BUT_IDX, 0);
    check("done_layer", LAYER, 5);
    check("done_rd_a", RD_ADDR_A, 0);
    check("done_rd_b", RD_ADDR_B, 16);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("done_wr_a", WR_ADDR_A, 0);
    check("done_wr_b", WR_ADDR_B, 16);

    // Enable gating: state b=3, l=1, WR=6/7
    goto(0, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("en0_but", BUT_IDX, 3);
    check("en0_layer", LAYER, 1);
    check("en0_wr_a", WR_ADDR_A, 6);
    check("en0_wr_b", WR_ADDR_B, 7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("en1_but", BUT_IDX, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("en1_layer", LAYER, 2);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("en1_wr_a", WR_ADDR_A, 8);
    check("en1_wr_b", WR_ADDR_B, 12);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("en1_rst_wr_a", WR_ADDR_A, 0);
    check("en1_rst_layer", LAYER, 0);

    // Mid-run ADDR_RST beats ADDR_EN
    goto(3, 9);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mid_wr_a", WR_ADDR_A, 17);
    check("mid_wr_b", WR_ADDR_B, 25);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_but", BUT_IDX, 0);
    check("mid_layer", LAYER, 0);
    check("mid_wr_a0", WR_ADDR_A, 0);
    check("mid_wr_b0", WR_ADDR_B, 0);

    // ADDR_RST held for several cycles, then RST mid-transform
    goto(1, 2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      check("hold_but", BUT_IDX, 0);
      check("hold_layer", LAYER, 0);
    end
    goto(2, 6);
    RST = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    RST = 1'b0;
    check("rst_mid_but", BUT_IDX, 0);
    check("rst_mid_layer", LAYER, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_iter_addr_gen.md
# fft_iter_addr_gen

Address generator for the iterative in-place radix-2 FFT core. It sits on the consumer side of the FFT control unit's strobe interface (BUT_STROB, ADDR_EN, ADDR_RST, LAY_EN). It holds the butterfly and layer indices and produces the two read addresses, two write addresses and twiddle ROM index for the current butterfly. The sample RAM and twiddle ROM are addressed directly from its outputs.

## Interface
- LAYERS, 5, number of FFT stages; N = 2^LAYERS points.
- ButtWL, 4, butterfly index width; must equal LAYERS-1.
- LayWL, 3, layer counter width; must hold the value LAYERS.
- AddrWL, 5, RAM address width; must equal LAYERS.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- EN  in  1  global enable; ADDR_RST, ADDR_EN, LAY_EN and BUT_STROB take effect only when EN=1.
- ADDR_RST  in  1  clears the butterfly and layer counters.
- ADDR_EN  in  1  advances the butterfly index by one.
- LAY_EN  in  1  advances the layer index by one.
- BUT_STROB  in  1  captures the current read addresses into the write-address registers.
- RD_ADDR_A  out  AddrWL  upper butterfly input address.
- RD_ADDR_B  out  AddrWL  lower butterfly input address.
- WR_ADDR_A  out  AddrWL  registered write address for result A.
- WR_ADDR_B  out  AddrWL  registered write address for result B.
- TW_ADDR  out  ButtWL  twiddle ROM index.
- LAYER  out  LayWL  current layer index.
- BUT_IDX  out  ButtWL  current butterfly index.
- DONE  out  1  high while LAYER == LAYERS.

## Operation
- State registers: b (ButtWL bits), l (LayWL bits), WR_ADDR_A and WR_ADDR_B.
- Address mapping, for layer s = l and butterfly b, combinational from b and l:
  - pos = b & (2^s - 1)
  - grp = b >> s
  - RD_ADDR_A = grp*2^(s+1) + pos, i.e. b with a 0 bit inserted at bit position s.
  - RD_ADDR_B = RD_ADDR_A + 2^s, i.e. b with a 1 bit inserted at bit position s.
  - TW_ADDR = pos << (LAYERS-1-s), truncated to ButtWL bits.
- When DONE=1, the mapping uses s = LAYERS-1 (clamped), and the addresses freeze at their last-layer values.
- Update priority per edge: RST > ADDR_RST > {ADDR_EN, LAY_EN, BUT_STROB}.
  - RST (regardless of EN) or ADDR_RST with EN=1: b=0, l=0, WR_ADDR_A=0, WR_ADDR_B=0.
  - ADDR_EN with EN=1 and DONE=0: b <= b+1 modulo 2^ButtWL. b wraps to 0 after 2^ButtWL-1.
  - LAY_EN with EN=1 and DONE=0: l <= l+1. l saturates at LAYERS.
  - BUT_STROB with EN=1: WR_ADDR_A <= RD_ADDR_A and WR_ADDR_B <= RD_ADDR_B.
- When ADDR_EN and LAY_EN are high in the same cycle (last butterfly of a layer), both apply: b wraps to 0 and l increments together.
- When DONE=1, ADDR_EN and LAY_EN are ignored. BUT_STROB still captures the frozen addresses.
- The block contains no FSM of its own. It is a counter and address datapath slaved to the control unit's strobes.

## Timing
- Reset values: b=0, l=0, so RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0, WR_ADDR_A=0, WR_ADDR_B=0, LAYER=0, BUT_IDX=0, DONE=0.
- RD_ADDR_A, RD_ADDR_B and TW_ADDR are valid in the same cycle as BUT_STROB, which is the control unit's read cycle.
- WR_ADDR_A and WR_ADDR_B are valid from the cycle after BUT_STROB. They hold until the next BUT_STROB, so they are stable through the write cycle two cycles later.
- ADDR_EN and LAY_EN arrive in the write cycle. New read addresses appear one cycle later, before the next BUT_STROB.
- Read latency from strobe to address: 0 cycles (combinational from registers).
- Write-address latency: 1 cycle after BUT_STROB.
- ADDR_RST held high for several cycles keeps all counters at 0.
- Mid-transform reset (RST or ADDR_RST) returns the block to the reset values on the next edge. No partial state is retained.

## Test plan
- Reset: assert RST for 2 cycles -> RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0, WR_ADDR_A=0, WR_ADDR_B=0, LAYER=0, DONE=0.
- Layer 2 mapping: reach l=2, b=5 -> RD_ADDR_A=9, RD_ADDR_B=13, TW_ADDR=4. Pulse BUT_STROB -> next cycle WR_ADDR_A=9, WR_ADDR_B=13.
- Layer 0 and layer 4 mapping:
  - l=0, b=5 -> RD_ADDR_A=10, RD_ADDR_B=11, TW_ADDR=0.
  - l=4, b=7 -> RD_ADDR_A=7, RD_ADDR_B=23, TW_ADDR=7.
- Full transform: drive the control-unit strobe pattern (BUT_STROB, delay, ADDR_EN; LAY_EN together with the 16th ADDR_EN) for 5×16 butterflies.
  - Every RAM address is read exactly once per layer.
  - After the final LAY_EN: LAYER=5, DONE=1.
  - Further ADDR_EN pulses leave BUT_IDX and RD_ADDR_* unchanged.
- Enable gating: with EN=0, pulse ADDR_EN, LAY_EN, ADDR_RST and BUT_STROB -> no state change. Repeat with EN=1 -> all take effect.
- Mid-run ADDR_RST: at l=3, b=9, assert ADDR_RST together with ADDR_EN -> next cycle b=0, l=0, WR_ADDR_A=0, WR_ADDR_B=0 (ADDR_RST wins).
